// File: rtl/gsc_pkg.sv
// gsc_pkg: register map, CTRL bit positions, gate FSM states and the
// 7-segment encoder shared by the gsc_meter slice.
package gsc_pkg;

  localparam logic [1:0] ADDR_ARR  = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_GATE = 2'd2;

  localparam int CTRL_SRC    = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_CLR    = 2;
  localparam int CTRL_PRE_LO = 4;

  localparam int GATE_SCALE = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_LATCH = 2'd2
  } gate_state_t;

  // bit0 = a ... bit6 = g, active high; codes 10..15 are blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gsc_spi_regs.sv
// gsc_spi_regs: oversampled write-only SPI slave feeding the ARR/CTRL/GATE
// registers; emits a one-cycle clear on CLR or on a MODE change.
module gsc_spi_regs
  import gsc_pkg::*;
#(
  parameter int GEN_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_spi_cs,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  input  logic [1:0]        i_spi_a,
  output logic [GEN_W-1:0]  o_arr,
  output logic [GATE_W-1:0] o_gate,
  output logic              o_src,
  output logic              o_mode,
  output logic [3:0]        o_pre,
  output logic              o_clr
);

  logic [2:0]        r_cs_sync;
  logic [2:0]        r_sck_sync;
  logic [1:0]        r_mosi_sync;
  logic [15:0]       r_shift;
  logic [4:0]        r_bits;
  logic [1:0]        r_addr;
  logic [GEN_W-1:0]  r_arr;
  logic [GATE_W-1:0] r_gate;
  logic              r_src;
  logic              r_mode;
  logic [3:0]        r_pre;
  logic              r_clr;

  logic w_sck_rise;
  logic w_cs_rise;
  logic w_commit;

  // [1] is the synchronised level, [2] the previous one for edge detection
  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2] & ~r_cs_sync[1];
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_commit   = w_cs_rise & r_bits[4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_sync   <= 3'b111;
      r_sck_sync  <= 3'b000;
      r_mosi_sync <= 2'b00;
      r_shift     <= '0;
      r_bits      <= '0;
      r_addr      <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], i_spi_cs};
      r_sck_sync  <= {r_sck_sync[1:0], i_spi_clk};
      r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
      if (!r_cs_sync[1]) r_addr <= i_spi_a;
      if (w_sck_rise) r_shift <= {r_shift[14:0], r_mosi_sync[1]};
      if (r_cs_sync[1]) r_bits <= '0;
      else if (w_sck_rise && !r_bits[4]) r_bits <= r_bits + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arr  <= '0;
      r_gate <= '0;
      r_src  <= 1'b0;
      r_mode <= 1'b0;
      r_pre  <= '0;
      r_clr  <= 1'b0;
    end else begin
      r_clr <= 1'b0;
      if (w_commit) begin
        case (r_addr)
          ADDR_ARR:  r_arr <= r_shift[GEN_W-1:0];
          ADDR_CTRL: begin
            r_src  <= r_shift[CTRL_SRC];
            r_mode <= r_shift[CTRL_MODE];
            r_pre  <= r_shift[CTRL_PRE_LO +: 4];
            r_clr  <= r_shift[CTRL_CLR] | (r_shift[CTRL_MODE] != r_mode);
          end
          ADDR_GATE: r_gate <= r_shift[GATE_W-1:0];
          default:   ;
        endcase
      end
    end
  end

  assign o_arr  = r_arr;
  assign o_gate = r_gate;
  assign o_src  = r_src;
  assign o_mode = r_mode;
  assign o_pre  = r_pre;
  assign o_clr  = r_clr;

endmodule

// File: rtl/gsc_meter.sv
// gsc_meter: prescaled square-wave generator, BCD totalizer / gated frequency
// meter and registered 7-segment drive, configured through gsc_spi_regs.
//
// state    | meaning
// ST_IDLE  | totalize mode, or freshly cleared; next cycle opens a window
// ST_OPEN  | gate window running, counting events, timer counting down
// ST_LATCH | last cycle of the window: count -> display, window reloads
module gsc_meter
  import gsc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int GEN_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                counter_in,
  input  logic                spi_cs,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  input  logic [1:0]          spi_a,
  output logic                gen,
  output logic [7*DIGITS-1:0] seg,
  output logic                overflow,
  output logic                gate_busy
);

  localparam int TW = GATE_W + 9;

  logic [GEN_W-1:0]  w_arr;
  logic [GATE_W-1:0] w_gate;
  logic              w_src;
  logic              w_mode;
  logic [3:0]        w_pre;
  logic              w_clr;

  gsc_spi_regs #(.GEN_W(GEN_W), .GATE_W(GATE_W)) u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_spi_cs   (spi_cs),
    .i_spi_clk  (spi_clk),
    .i_spi_mosi (spi_mosi),
    .i_spi_a    (spi_a),
    .o_arr      (w_arr),
    .o_gate     (w_gate),
    .o_src      (w_src),
    .o_mode     (w_mode),
    .o_pre      (w_pre),
    .o_clr      (w_clr)
  );

  logic [15:0]      r_psc;
  logic [GEN_W-1:0] r_gen_cnt;
  logic             r_gen;
  logic             r_gen_d;
  logic [2:0]       r_cin_sync;
  logic             w_tick;
  logic [15:0]      w_psc_load;
  logic             w_inc;

  assign w_tick     = (r_psc == 16'd0);
  assign w_psc_load = (16'd1 << w_pre) - 16'd1;
  assign w_inc      = w_src ? (r_gen & ~r_gen_d) : (r_cin_sync[1] & ~r_cin_sync[2]);

  // New PRE/ARR values are picked up at the next tick; cnt is never reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_psc      <= '0;
      r_gen_cnt  <= '0;
      r_gen      <= 1'b0;
      r_gen_d    <= 1'b0;
      r_cin_sync <= '0;
    end else begin
      r_gen_d    <= r_gen;
      r_cin_sync <= {r_cin_sync[1:0], counter_in};
      if (w_tick) begin
        r_psc <= w_psc_load;
        if (r_gen_cnt == w_arr) begin
          r_gen_cnt <= '0;
          r_gen     <= ~r_gen;
        end else begin
          r_gen_cnt <= r_gen_cnt + GEN_W'(1);
        end
      end else begin
        r_psc <= r_psc - 16'd1;
      end
    end
  end

  logic [DIGITS-1:0][3:0] r_cnt;
  logic [DIGITS-1:0][3:0] r_disp;
  logic [DIGITS-1:0][3:0] w_cnt_inc;
  logic                   w_carry;
  logic                   r_ovf;
  logic                   r_disp_ovf;
  gate_state_t            r_state;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_win;
  logic [TW-1:0]          w_win_load;

  always_comb begin
    w_cnt_inc = r_cnt;
    w_carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_cnt[i] == 4'd9) begin
          w_cnt_inc[i] = 4'd0;
        end else begin
          w_cnt_inc[i] = r_cnt[i] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
  end

  // Loaded with window-2 so OPEN (N-1 cycles) plus LATCH (1 cycle) spans N
  assign w_win      = TW'({1'b0, w_gate} + (GATE_W + 1)'(1)) * TW'(GATE_SCALE);
  assign w_win_load = w_win - TW'(2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_ovf      <= 1'b0;
      r_disp_ovf <= 1'b0;
      r_timer    <= '0;
    end else if (w_clr) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_ovf      <= 1'b0;
      r_disp_ovf <= 1'b0;
    end else if (!w_mode) begin
      r_state <= ST_IDLE;
      if (w_inc) begin
        r_cnt <= w_cnt_inc;
        if (w_carry) r_ovf <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_OPEN;
          r_cnt   <= '0;
          r_timer <= w_win_load;
        end
        ST_OPEN: begin
          if (r_timer == '0) r_state <= ST_LATCH;
          else r_timer <= r_timer - TW'(1);
          if (w_inc) begin
            r_cnt <= w_cnt_inc;
            if (w_carry) r_ovf <= 1'b1;
          end
        end
        ST_LATCH: begin
          r_disp     <= w_inc ? w_cnt_inc : r_cnt;
          r_disp_ovf <= r_ovf | (w_inc & w_carry);
          r_ovf      <= r_ovf | (w_inc & w_carry);
          r_cnt      <= '0;
          r_timer    <= w_win_load;
          r_state    <= ST_OPEN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [7*DIGITS-1:0] r_seg;
  logic [7*DIGITS-1:0] w_seg_nxt;

  always_comb begin
    w_seg_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_seg_nxt[7*i +: 7] = seg7(w_mode ? r_disp[i] : r_cnt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_seg <= {DIGITS{7'h3F}};
    else          r_seg <= w_seg_nxt;
  end

  assign gen       = r_gen;
  assign seg       = r_seg;
  assign overflow  = w_mode ? r_disp_ovf : r_ovf;
  assign gate_busy = (r_state != ST_IDLE);

endmodule
